// File: rtl/serial_wb_cmd_decoder.sv
// Serial command decoder: turns a UART byte stream into single-byte bus
// writes/reads for the register peripherals and returns read bytes to the
// UART transmitter. Frame: command, address, then write payload (if any).
// Command byte: bit7 write(1)/read(0), bit6 auto-increment, bits[5:0] count-1.
//
// tx handshake: tx_valid_o rises with tx_data_o and both hold steady until the
// cycle in which tx_valid_o & tx_ready_i are both high; that cycle is the
// transfer, and tx_valid_o is low the following cycle.
module serial_wb_cmd_decoder #(
    parameter int ADDR_W         = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_valid_i,
    output logic [7:0]        tx_data_o,
    output logic              tx_valid_o,
    input  logic              tx_ready_i,
    output logic [ADDR_W-1:0] address_o,
    output logic [7:0]        data_o,
    input  logic [7:0]        data_i,
    output logic              writestrobe_o,
    output logic              readstrobe_o,
    output logic              busy_o,
    output logic              timeout_o
);

    // Idle counter only has to hold TIMEOUT_CYCLES-1.
    localparam int               CNT_W      = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit               TIMEOUT_EN = (TIMEOUT_CYCLES > 0);

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        WRITE_DATA,
        READ_ISSUE,
        READ_WAIT_TX
    } state_t;

    state_t              state_q, state_d;
    logic                is_write_q, is_write_d;
    logic                auto_inc_q, auto_inc_d;
    logic [5:0]          count_q, count_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          data_q, data_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                tx_valid_q, tx_valid_d;
    logic                wstb_q, wstb_d;
    logic                rstb_q, rstb_d;
    logic                timeout_q, timeout_d;
    logic [CNT_W-1:0]    idle_cnt_q, idle_cnt_d;

    logic                timed;
    logic                expire;

    // The timeout only watches the states that wait on rx bytes; a byte in
    // the expiry cycle wins over the abort.
    assign timed  = (state_q == GET_ADDR) || (state_q == WRITE_DATA);
    assign expire = TIMEOUT_EN && timed && !rx_valid_i && (idle_cnt_q == CNT_LAST);

    // Next-state and next-output logic for the frame parser.
    always_comb begin
        state_d    = state_q;
        is_write_d = is_write_q;
        auto_inc_d = auto_inc_q;
        count_d    = count_q;
        addr_d     = addr_q;
        data_d     = data_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        wstb_d     = 1'b0;
        rstb_d     = 1'b0;
        timeout_d  = 1'b0;
        idle_cnt_d = (timed && !rx_valid_i && !expire) ? idle_cnt_q + CNT_W'(1) : '0;

        // Address moves on only after the write strobe cycle has been seen.
        if (wstb_q && auto_inc_q) begin
            addr_d = addr_q + ADDR_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (rx_valid_i) begin
                    is_write_d = rx_data_i[7];
                    auto_inc_d = rx_data_i[6];
                    count_d    = rx_data_i[5:0];
                    state_d    = GET_ADDR;
                end
            end
            GET_ADDR: begin
                if (rx_valid_i) begin
                    addr_d = ADDR_W'(rx_data_i);
                    if (is_write_q) begin
                        state_d = WRITE_DATA;
                    end else begin
                        state_d = READ_ISSUE;
                        rstb_d  = 1'b1;
                    end
                end else if (expire) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end
            end
            WRITE_DATA: begin
                if (rx_valid_i) begin
                    data_d  = rx_data_i;
                    wstb_d  = 1'b1;
                    count_d = count_q - 6'd1;
                    if (count_q == 6'd0) begin
                        state_d = IDLE;
                    end
                end else if (expire) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end
            end
            READ_ISSUE: begin
                // readstrobe_o is high this cycle; capture the peripheral's answer.
                tx_data_d  = data_i;
                tx_valid_d = 1'b1;
                state_d    = READ_WAIT_TX;
            end
            READ_WAIT_TX: begin
                if (tx_valid_q && tx_ready_i) begin
                    tx_valid_d = 1'b0;
                    if (auto_inc_q) begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                    if (count_q == 6'd0) begin
                        state_d = IDLE;
                    end else begin
                        count_d = count_q - 6'd1;
                        state_d = READ_ISSUE;
                        rstb_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q    <= IDLE;
            is_write_q <= 1'b0;
            auto_inc_q <= 1'b0;
            count_q    <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            wstb_q     <= 1'b0;
            rstb_q     <= 1'b0;
            timeout_q  <= 1'b0;
            idle_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            is_write_q <= is_write_d;
            auto_inc_q <= auto_inc_d;
            count_q    <= count_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            wstb_q     <= wstb_d;
            rstb_q     <= rstb_d;
            timeout_q  <= timeout_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

    assign tx_data_o     = tx_data_q;
    assign tx_valid_o    = tx_valid_q;
    assign address_o     = addr_q;
    assign data_o        = data_q;
    assign writestrobe_o = wstb_q;
    assign readstrobe_o  = rstb_q;
    assign timeout_o     = timeout_q;
    assign busy_o        = (state_q != IDLE);

endmodule
